// File: rtl/reg_bank_shadow.sv
// reg_bank_shadow
// Bank of NUM_REGS control registers with byte-strobed write/set/clear/toggle
// writes into a shadow copy, and a one-cycle commit that copies every shadow
// register into the active copy so downstream logic sees an atomic update.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | accepting writes (wr_ready=1); commit request moves to COMMIT
// ST_COMMIT | single cycle: active <= shadow, dirty cleared, writes stalled
module reg_bank_shadow #(
    parameter int               WIDTH       = 8,
    parameter int               NUM_REGS    = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [WIDTH/8-1:0]        wr_strb,
    input  logic [1:0]                wr_mode,
    output logic                      wr_err,
    input  logic                      commit,
    output logic                      dirty,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    input  logic                      rd_shadow,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic [NUM_REGS*WIDTH-1:0] q
);

    localparam int NB = WIDTH / 8;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    localparam logic [1:0] MODE_WRITE  = 2'b00;
    localparam logic [1:0] MODE_SET    = 2'b01;
    localparam logic [1:0] MODE_CLEAR  = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    // One extra bit so NUM_REGS itself is representable when it is a power of two.
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             wr_fire;
    logic             wr_in_range;
    logic [WIDTH-1:0] rd_sel;

    logic [WIDTH-1:0] shadow_q [NUM_REGS];
    logic [WIDTH-1:0] active_q [NUM_REGS];

    // Byte-wise read-modify-write of one register; unstrobed bytes pass through.
    function automatic logic [WIDTH-1:0] apply_write(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] data,
        input logic [NB-1:0]    strb,
        input logic [1:0]       mode
    );
        logic [WIDTH-1:0] res;
        res = cur;
        for (int b = 0; b < NB; b++) begin
            if (strb[b]) begin
                case (mode)
                    MODE_WRITE:  res[8*b +: 8] = data[8*b +: 8];
                    MODE_SET:    res[8*b +: 8] = cur[8*b +: 8] | data[8*b +: 8];
                    MODE_CLEAR:  res[8*b +: 8] = cur[8*b +: 8] & ~data[8*b +: 8];
                    MODE_TOGGLE: res[8*b +: 8] = cur[8*b +: 8] ^ data[8*b +: 8];
                    default:     res[8*b +: 8] = cur[8*b +: 8];
                endcase
            end
        end
        return res;
    endfunction

    // Writes are only stalled in COMMIT, so ready is a plain decode of the state flop.
    assign wr_ready    = (state_q == ST_IDLE);
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = ({1'b0, wr_addr} < NUM_REGS_W);

    // Next-state: a commit seen in COMMIT is dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (commit) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shadow registers take accepted in-range writes; out-of-range writes match no index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                shadow_q[k] <= RESET_VALUE;
            end
        end else if (wr_fire && wr_in_range) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_addr == ADDR_W'(k)) begin
                    shadow_q[k] <= apply_write(shadow_q[k], wr_data, wr_strb, wr_mode);
                end
            end
        end
    end

    // Active registers copy the whole shadow bank in the COMMIT cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                active_q[k] <= RESET_VALUE;
            end
        end else if (state_q == ST_COMMIT) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                active_q[k] <= shadow_q[k];
            end
        end
    end

    // Dirty tracks in-range writes since the last commit (no writes land in COMMIT).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty <= 1'b0;
        end else if (state_q == ST_COMMIT) begin
            dirty <= 1'b0;
        end else if (wr_fire && wr_in_range) begin
            dirty <= 1'b1;
        end
    end

    // Error pulse for an accepted write to a non-existent register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_fire && !wr_in_range;
        end
    end

    // Read mux over the pre-edge register values; unmatched addresses read as zero.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k)) begin
                rd_sel = rd_shadow ? shadow_q[k] : active_q[k];
            end
        end
    end

    // Registered read port; data holds when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_sel;
            end
        end
    end

    // Flatten the active bank onto q.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign q[g*WIDTH +: WIDTH] = active_q[g];
    end

endmodule

// File: tb/tb_reg_bank_shadow.sv
// Self-checking bench for reg_bank_shadow: a 4-register bank for the main
// function and a 3-register bank for out-of-range address handling.
module tb_reg_bank_shadow;

    localparam logic [1:0] M_WRITE  = 2'b00;
    localparam logic [1:0] M_SET    = 2'b01;
    localparam logic [1:0] M_CLEAR  = 2'b10;
    localparam logic [1:0] M_TOGGLE = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        wr_valid, wr_ready, wr_err, commit, dirty, rd_en, rd_shadow, rd_valid;
    logic [1:0]  wr_addr, rd_addr, wr_strb, wr_mode;
    logic [15:0] wr_data, rd_data;
    logic [63:0] q;

    logic        e_wr_valid, e_wr_ready, e_wr_err, e_commit, e_dirty, e_rd_en, e_rd_shadow, e_rd_valid;
    logic [1:0]  e_wr_addr, e_rd_addr, e_wr_strb, e_wr_mode;
    logic [15:0] e_wr_data, e_rd_data;
    logic [47:0] e_q;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] rd_exp_q [$];
    logic [15:0] e_rd_exp_q [$];
    logic [15:0] exp_rd;
    logic [15:0] sh_m  [4];
    logic [15:0] act_m [4];

    reg_bank_shadow #(.WIDTH(16), .NUM_REGS(4), .RESET_VALUE(16'h00FF)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .wr_mode(wr_mode), .wr_err(wr_err),
        .commit(commit), .dirty(dirty),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_shadow(rd_shadow),
        .rd_data(rd_data), .rd_valid(rd_valid), .q(q)
    );

    reg_bank_shadow #(.WIDTH(16), .NUM_REGS(3), .RESET_VALUE(16'h00FF)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(e_wr_valid), .wr_ready(e_wr_ready), .wr_addr(e_wr_addr), .wr_data(e_wr_data),
        .wr_strb(e_wr_strb), .wr_mode(e_wr_mode), .wr_err(e_wr_err),
        .commit(e_commit), .dirty(e_dirty),
        .rd_en(e_rd_en), .rd_addr(e_rd_addr), .rd_shadow(e_rd_shadow),
        .rd_data(e_rd_data), .rd_valid(e_rd_valid), .q(e_q)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_write(input logic [15:0] old, input logic [15:0] d,
                                                input logic [1:0] s, input logic [1:0] m);
        logic [15:0] r;
        r = old;
        for (int b = 0; b < 2; b++) begin
            if (s[b]) begin
                if (m == M_WRITE)       r[8*b +: 8] = d[8*b +: 8];
                else if (m == M_SET)    r[8*b +: 8] = old[8*b +: 8] | d[8*b +: 8];
                else if (m == M_CLEAR)  r[8*b +: 8] = old[8*b +: 8] & ~d[8*b +: 8];
                else                    r[8*b +: 8] = old[8*b +: 8] ^ d[8*b +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] model_q();
        return {act_m[3], act_m[2], act_m[1], act_m[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [15:0] d,
                            input logic [1:0] s, input logic [1:0] m);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s; wr_mode = m;
        tick();
        wr_valid = 1'b0;
        sh_m[a] = model_write(sh_m[a], d, s, m);
    endtask

    task automatic issue_read(input logic [1:0] a, input logic sh, input logic [15:0] expv);
        rd_en = 1'b1; rd_addr = a; rd_shadow = sh;
        rd_exp_q.push_back(expv);
    endtask

    task automatic test_reset();
        tests_run++;
        if (q !== 64'h00FF_00FF_00FF_00FF) begin
            tests_failed++; $display("FAIL reset_q: got %h expected %h", q, 64'h00FF_00FF_00FF_00FF);
        end
        tests_run++;
        if (dirty !== 1'b0 || wr_ready !== 1'b1 || wr_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags: dirty=%b wr_ready=%b wr_err=%b expected 0 1 0", dirty, wr_ready, wr_err);
        end
        tests_run++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_rd: rd_valid=%b rd_data=%h expected 0 0000", rd_valid, rd_data);
        end
        tests_run++;
        if (e_q !== 48'h00FF_00FF_00FF) begin
            tests_failed++; $display("FAIL reset_q3: got %h expected %h", e_q, 48'h00FF_00FF_00FF);
        end
    endtask

    task automatic test_write_modes();
        logic [1:0]  mode_t [4] = '{M_WRITE, M_SET, M_CLEAR, M_TOGGLE};
        logic [15:0] data_t [4] = '{16'h1234, 16'h0100, 16'h0011, 16'hFFFF};
        logic [1:0]  strb_t [4] = '{2'b10, 2'b11, 2'b11, 2'b01};
        logic [15:0] exp_t  [4] = '{16'h12FF, 16'h13FF, 16'h13EE, 16'h1311};
        for (int i = 0; i < 4; i++) begin
            do_write(2'd1, data_t[i], strb_t[i], mode_t[i]);
            tests_run++;
            if (dirty !== 1'b1 || q !== 64'h00FF_00FF_00FF_00FF) begin
                tests_failed++; $display("FAIL mode%0d_dirty_q: dirty=%b q=%h expected 1 %h", i, dirty, q, 64'h00FF_00FF_00FF_00FF);
            end
            issue_read(2'd1, 1'b1, exp_t[i]);
            tick();
            rd_en = 1'b0;
            tests_run++;
            exp_rd = rd_exp_q.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
                tests_failed++; $display("FAIL mode%0d_shadow: rd_valid=%b rd_data=%h expected 1 %h", i, rd_valid, rd_data, exp_rd);
            end
        end
        issue_read(2'd1, 1'b0, 16'h00FF);
        tick();
        rd_en = 1'b0;
        tests_run++;
        exp_rd = rd_exp_q.pop_front();
        if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
            tests_failed++; $display("FAIL mode_active: rd_valid=%b rd_data=%h expected 1 %h", rd_valid, rd_data, exp_rd);
        end
    endtask

    task automatic test_commit();
        wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 16'hBEEF; wr_strb = 2'b11; wr_mode = M_WRITE;
        commit = 1'b1;
        tick();
        wr_valid = 1'b0;
        sh_m[2] = 16'hBEEF;
        tests_run++;
        if (wr_ready !== 1'b0 || q !== 64'h00FF_00FF_00FF_00FF) begin
            tests_failed++; $display("FAIL commit_cycle: wr_ready=%b q=%h expected 0 %h", wr_ready, q, 64'h00FF_00FF_00FF_00FF);
        end
        // commit stays high through COMMIT; active read still sees pre-commit value
        issue_read(2'd2, 1'b0, 16'h00FF);
        tick();
        commit = 1'b0;
        rd_en = 1'b0;
        for (int k = 0; k < 4; k++) act_m[k] = sh_m[k];
        tests_run++;
        if (q !== model_q() || q[47:32] !== 16'hBEEF) begin
            tests_failed++; $display("FAIL commit_q: got %h expected %h", q, model_q());
        end
        tests_run++;
        if (dirty !== 1'b0 || wr_ready !== 1'b1) begin
            tests_failed++; $display("FAIL commit_done: dirty=%b wr_ready=%b expected 0 1", dirty, wr_ready);
        end
        tests_run++;
        exp_rd = rd_exp_q.pop_front();
        if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
            tests_failed++; $display("FAIL commit_read_active: rd_valid=%b rd_data=%h expected 1 %h", rd_valid, rd_data, exp_rd);
        end
        tick();
        tests_run++;
        if (wr_ready !== 1'b1) begin
            tests_failed++; $display("FAIL commit_drop_second: wr_ready=%b expected 1", wr_ready);
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tests_run++;
        if (wr_ready !== 1'b0) begin
            tests_failed++; $display("FAIL commit_next_idle: wr_ready=%b expected 0", wr_ready);
        end
        tick();
        tests_run++;
        if (wr_ready !== 1'b1 || q !== model_q()) begin
            tests_failed++; $display("FAIL commit_recommit: wr_ready=%b q=%h expected 1 %h", wr_ready, q, model_q());
        end
        do_write(2'd1, 16'hFFFF, 2'b00, M_WRITE);
        tests_run++;
        if (dirty !== 1'b1) begin
            tests_failed++; $display("FAIL strb0_dirty: dirty=%b expected 1", dirty);
        end
        issue_read(2'd1, 1'b1, 16'h1311);
        tick();
        rd_en = 1'b0;
        tests_run++;
        exp_rd = rd_exp_q.pop_front();
        if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
            tests_failed++; $display("FAIL strb0_value: rd_valid=%b rd_data=%h expected 1 %h", rd_valid, rd_data, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 16'h0A0B; wr_strb = 2'b11; wr_mode = M_WRITE;
        issue_read(2'd0, 1'b1, sh_m[0]);
        tick();
        sh_m[0] = model_write(sh_m[0], 16'h0A0B, 2'b11, M_WRITE);
        tests_run++;
        exp_rd = rd_exp_q.pop_front();
        if (rd_valid !== 1'b1 || rd_data !== exp_rd || wr_ready !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_first: rd_data=%h wr_ready=%b expected %h 1", rd_data, wr_ready, exp_rd);
        end
        wr_addr = 2'd1; wr_data = 16'h0004; wr_mode = M_SET;
        issue_read(2'd0, 1'b1, 16'h0A0B);
        tick();
        wr_valid = 1'b0;
        sh_m[1] = model_write(sh_m[1], 16'h0004, 2'b11, M_SET);
        tests_run++;
        exp_rd = rd_exp_q.pop_front();
        if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
            tests_failed++; $display("FAIL b2b_second: rd_valid=%b rd_data=%h expected 1 %h", rd_valid, rd_data, exp_rd);
        end
        issue_read(2'd1, 1'b1, 16'h1315);
        tick();
        rd_en = 1'b0;
        tests_run++;
        exp_rd = rd_exp_q.pop_front();
        if (rd_valid !== 1'b1 || rd_data !== exp_rd || sh_m[1] !== exp_rd) begin
            tests_failed++; $display("FAIL b2b_set: rd_data=%h model=%h expected %h", rd_data, sh_m[1], exp_rd);
        end
    endtask

    task automatic test_read();
        do_write(2'd3, 16'hA5C3, 2'b11, M_WRITE);
        issue_read(2'd3, 1'b1, 16'hA5C3);
        tick();
        tests_run++;
        exp_rd = rd_exp_q.pop_front();
        if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
            tests_failed++; $display("FAIL read_shadow3: rd_valid=%b rd_data=%h expected 1 %h", rd_valid, rd_data, exp_rd);
        end
        issue_read(2'd3, 1'b0, 16'h00FF);
        tick();
        rd_en = 1'b0;
        tests_run++;
        exp_rd = rd_exp_q.pop_front();
        if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
            tests_failed++; $display("FAIL read_active3: rd_valid=%b rd_data=%h expected 1 %h", rd_valid, rd_data, exp_rd);
        end
        tick();
        tests_run++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h00FF) begin
            tests_failed++; $display("FAIL read_hold: rd_valid=%b rd_data=%h expected 0 00ff", rd_valid, rd_data);
        end
    endtask

    task automatic test_wr_err();
        e_wr_valid = 1'b1; e_wr_addr = 2'd3; e_wr_data = 16'h5555; e_wr_strb = 2'b11; e_wr_mode = M_WRITE;
        tick();
        e_wr_valid = 1'b0;
        tests_run++;
        if (e_wr_err !== 1'b1 || e_dirty !== 1'b0 || e_q !== 48'h00FF_00FF_00FF) begin
            tests_failed++; $display("FAIL err_pulse: wr_err=%b dirty=%b q=%h expected 1 0 %h", e_wr_err, e_dirty, e_q, 48'h00FF_00FF_00FF);
        end
        tick();
        tests_run++;
        if (e_wr_err !== 1'b0) begin
            tests_failed++; $display("FAIL err_one_cycle: wr_err=%b expected 0", e_wr_err);
        end
        for (int k = 0; k < 4; k++) begin
            e_rd_en = 1'b1; e_rd_addr = 2'(k); e_rd_shadow = 1'b1;
            e_rd_exp_q.push_back((k == 3) ? 16'h0000 : 16'h00FF);
            tick();
            e_rd_en = 1'b0;
            tests_run++;
            exp_rd = e_rd_exp_q.pop_front();
            if (e_rd_valid !== 1'b1 || e_rd_data !== exp_rd) begin
                tests_failed++; $display("FAIL err_read%0d: rd_valid=%b rd_data=%h expected 1 %h", k, e_rd_valid, e_rd_data, exp_rd);
            end
        end
        e_wr_valid = 1'b1; e_wr_addr = 2'd2; e_wr_data = 16'h0F00; e_wr_strb = 2'b10; e_wr_mode = M_SET;
        tick();
        e_wr_valid = 1'b0;
        tests_run++;
        if (e_wr_err !== 1'b0 || e_dirty !== 1'b1) begin
            tests_failed++; $display("FAIL err_inrange: wr_err=%b dirty=%b expected 0 1", e_wr_err, e_dirty);
        end
    endtask

    task automatic test_reset_mid_commit();
        do_write(2'd0, 16'h1111, 2'b11, M_WRITE);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tests_run++;
        if (wr_ready !== 1'b0 || dirty !== 1'b1) begin
            tests_failed++; $display("FAIL rstmid_pre: wr_ready=%b dirty=%b expected 0 1", wr_ready, dirty);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (q !== 64'h00FF_00FF_00FF_00FF || dirty !== 1'b0 || wr_ready !== 1'b1 || rd_data !== 16'h0000) begin
            tests_failed++; $display("FAIL rstmid_async: q=%h dirty=%b wr_ready=%b rd_data=%h expected all-00ff 0 1 0000", q, dirty, wr_ready, rd_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sh_m[k]  = 16'h00FF;
            act_m[k] = 16'h00FF;
        end
        tick();
        tests_run++;
        if (q !== model_q() || wr_ready !== 1'b1 || dirty !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_after: q=%h wr_ready=%b dirty=%b expected %h 1 0", q, wr_ready, dirty, model_q());
        end
        issue_read(2'd0, 1'b1, sh_m[0]);
        tick();
        rd_en = 1'b0;
        tests_run++;
        exp_rd = rd_exp_q.pop_front();
        if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
            tests_failed++; $display("FAIL rstmid_shadow0: rd_valid=%b rd_data=%h expected 1 %h", rd_valid, rd_data, exp_rd);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; wr_mode = '0;
        commit = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_shadow = 1'b0;
        e_wr_valid = 1'b0; e_wr_addr = '0; e_wr_data = '0; e_wr_strb = '0; e_wr_mode = '0;
        e_commit = 1'b0; e_rd_en = 1'b0; e_rd_addr = '0; e_rd_shadow = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sh_m[k]  = 16'h00FF;
            act_m[k] = 16'h00FF;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_write_modes();
        test_commit();
        test_back_to_back();
        test_read();
        test_wr_err();
        test_reset_mid_commit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_bank_shadow.md
# reg_bank_shadow

Parametrised bank of NUM_REGS registers, each WIDTH bits, with byte-strobed writes, four write modes (write/set/clear/toggle) and a shadow/active double-buffer. Writes land in a shadow copy. A commit request copies all shadow registers to the active registers in one cycle, so downstream logic sees a consistent update. Successor to the single 8-bit enable register; used wherever a group of control registers must change atomically.

## Interface
- WIDTH, 8: register width in bits; multiple of 8, minimum 8
- NUM_REGS, 4: number of registers; minimum 2
- RESET_VALUE, 0: reset value of every shadow and active register (WIDTH bits)
- ADDR_W, $clog2(NUM_REGS): address width (derived)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accept; transfer when wr_valid && wr_ready
- wr_addr  in  ADDR_W  target register
- wr_data  in  WIDTH  write operand
- wr_strb  in  WIDTH/8  byte strobes; bit i covers bits [8i+7:8i]
- wr_mode  in  2  00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE
- wr_err  out  1  one-cycle pulse: accepted write had wr_addr >= NUM_REGS
- commit  in  1  request shadow-to-active copy
- dirty  out  1  shadow written since last commit
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read register
- rd_shadow  in  1  1 = read shadow copy, 0 = read active copy
- rd_data  out  WIDTH  read data, registered
- rd_valid  out  1  rd_data valid
- q  out  NUM_REGS*WIDTH  active registers, reg k at [k*WIDTH +: WIDTH]

## Operation
- Reset: all shadow and active registers = RESET_VALUE; FSM = IDLE; wr_ready=1, wr_err=0, dirty=0, rd_data=0, rd_valid=0.
- FSM states:
  - IDLE: wr_ready=1. commit=1 moves to COMMIT next cycle.
  - COMMIT: lasts exactly one cycle. wr_ready=0. active[k] <= shadow[k] for all k. dirty <= 0. Returns to IDLE.
  - commit asserted while in COMMIT is ignored (not queued).
- Accepted write to in-range addr. For each byte with its strobe set:
  - WRITE: byte = data
  - SET: byte |= data
  - CLEAR: byte &= ~data
  - TOGGLE: byte ^= data
- Bytes with strobe clear are unchanged.
- Each in-range accepted write sets dirty, including wr_strb=0.
- Out-of-range accepted write: no register changes, dirty unchanged, wr_err=1 next cycle.
- A write accepted in the same IDLE cycle as commit updates the shadow first and is included in the copy made in the COMMIT cycle.
- Reads:
  - rd_en=1 samples rd_addr and rd_shadow.
  - Next cycle: rd_valid=1 and rd_data = register value before that edge's update (the value present in the rd_en cycle).
  - Out-of-range address returns 0.
  - rd_en=0: rd_valid=0 next cycle and rd_data holds its last value.
- q changes only on COMMIT-cycle edges or reset.

## Timing
- Write-to-shadow latency 1 cycle; visible through shadow read issued the following cycle.
- Commit latency: commit in cycle N (IDLE) -> COMMIT in N+1 -> q updated at end of N+1, visible N+2.
- wr_ready is registered (state-decoded), low only in COMMIT; back-to-back writes at full rate otherwise.
- Back-to-back commits: second commit in COMMIT cycle dropped; commit in the next IDLE cycle accepted.
- Asynchronous reset mid-COMMIT: immediate return to reset values; the copy is abandoned.
- Reads are never stalled; a read during COMMIT of the active copy returns pre-commit value.

## Test plan
- WIDTH=16, NUM_REGS=4, RESET_VALUE=16'h00FF. After reset: q=64'h00FF00FF00FF00FF, dirty=0, wr_ready=1, rd_valid=0.
- Write reg1 mode WRITE data 16'h1234, strb 2'b10. Response: shadow1=16'h12FF, q unchanged, dirty=1. Then SET 16'h0100 strb 11 -> 16'h13FF; CLEAR 16'h0011 strb 11 -> 16'h13EE; TOGGLE 16'hFFFF strb 01 -> 16'h1311.
- Write reg2=16'hBEEF together with commit in the same cycle. Response: wr_ready=0 the next cycle; reg2 slice of q=16'hBEEF two cycles after commit; dirty=0; a second commit during COMMIT changes nothing.
- Write addr 3 (valid) then shadow read addr 3 and active read addr 3. Response: rd_data=new value (shadow) and 16'h00FF (active), each with rd_valid one cycle after rd_en.
- NUM_REGS=3, write addr 3. Response: wr_err pulses 1 cycle; no register or dirty change; read addr 3 -> rd_data=0.
- Write reg0 then commit, and assert rst_n=0 during the COMMIT cycle. Response: q, shadow and dirty return to reset values immediately; FSM IDLE after release.
